// File: rtl/crc_check_engine_pkg.sv
// Shared types and defaults for the multi-channel CRC check engine.
package crc_check_engine_pkg;

   localparam int unsigned CRC_W_DEF = 4;
   localparam logic [CRC_W_DEF-1:0] POLY_DEF = 4'h3;
   localparam int unsigned BITS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      RESULT = 2'd2
   } state_t;

   // One MSB-first fold of a default-size chunk into a default-width remainder.
   function automatic logic [CRC_W_DEF-1:0] crc_fold(input logic [CRC_W_DEF-1:0] crc,
                                                      input logic [BITS_DEF-1:0] chunk);
      logic [CRC_W_DEF-1:0] r;
      r = crc;
      for (int i = BITS_DEF - 1; i >= 0; i--) begin
         if (r[CRC_W_DEF-1] ^ chunk[i]) r = (r << 1) ^ POLY_DEF;
         else                           r = r << 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_check_engine_if.sv
// Channel request bus and result bus of the CRC check engine.
interface crc_check_engine_if #(
   parameter int unsigned N_CH   = 16,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CRC_W  = 4
);
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0]        in_valid;
   logic [N_CH-1:0]        in_ready;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH*CRC_W-1:0]  in_crc;
   logic                   res_valid;
   logic                   res_ready;
   logic [CH_W-1:0]        res_ch;
   logic                   res_ok;
   logic [CRC_W-1:0]       res_crc;

   modport master (
      output in_valid, in_data, in_crc, res_ready,
      input  in_ready, res_valid, res_ch, res_ok, res_crc
   );

   modport slave (
      input  in_valid, in_data, in_crc, res_ready,
      output in_ready, res_valid, res_ch, res_ok, res_crc
   );
endinterface

// File: rtl/crc_check_engine_crc_step.sv
// Combinational fold of BITS data bits (MSB first) into a CRC_W remainder.
module crc_check_engine_crc_step #(
   parameter int unsigned      CRC_W = 4,
   parameter logic [CRC_W-1:0] POLY  = 4'h3,
   parameter int unsigned      BITS  = 8
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic [BITS-1:0]  chunk,
   output logic [CRC_W-1:0] crc_out
);
   always_comb begin
      crc_out = crc_in;
      for (int i = BITS - 1; i >= 0; i--) begin
         if (crc_out[CRC_W-1] ^ chunk[i]) crc_out = (crc_out << 1) ^ POLY;
         else                             crc_out = crc_out << 1;
      end
   end
endmodule

// File: rtl/crc_check_engine.sv
// Round-robin multi-channel CRC checker: one shared engine, BITS_PER_CYC bits per cycle,
// valid/ready result port and sticky error statistics.
module crc_check_engine
   import crc_check_engine_pkg::*;
#(
   parameter int unsigned      N_CH         = 16,
   parameter int unsigned      DATA_W       = 64,
   parameter int unsigned      CRC_W        = CRC_W_DEF,
   parameter logic [CRC_W-1:0] POLY         = CRC_W'(POLY_DEF),
   parameter int unsigned      BITS_PER_CYC = 8,
   parameter int unsigned      ERR_W        = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   crc_check_engine_if.slave bus,
   input  logic              clr_err,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [N_CH-1:0]   err_flags,
   output logic              busy
);
   localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned CALC_CYC = DATA_W / BITS_PER_CYC;
   localparam int unsigned CNT_W    = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;

   state_t             state_q, state_nx;
   logic [CH_W-1:0]    rr_q, rr_nx;
   logic [DATA_W-1:0]  sh_q, sh_nx;
   logic [CRC_W-1:0]   rcv_q, rcv_nx;
   logic [CRC_W-1:0]   acc_q, acc_nx;
   logic [CNT_W-1:0]   cnt_q, cnt_nx;
   logic               rv_q, rv_nx;
   logic [CH_W-1:0]    rch_q, rch_nx;
   logic               rok_q, rok_nx;
   logic [CRC_W-1:0]   rcrc_q, rcrc_nx;
   logic [ERR_W-1:0]   ecnt_q, ecnt_nx;
   logic [N_CH-1:0]    eflg_q, eflg_nx;
   logic               busy_q, busy_nx;

   logic               gnt_found;
   logic [CH_W-1:0]    gnt_idx;
   int unsigned        idx;
   logic [N_CH-1:0]    ready_c;
   logic [CRC_W-1:0]   step_crc;

   crc_check_engine_crc_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .BITS  (BITS_PER_CYC)
   ) u_step (
      .crc_in  (acc_q),
      .chunk   (sh_q[DATA_W-1 -: BITS_PER_CYC]),
      .crc_out (step_crc)
   );

   // Rotate-priority encoder: first requesting channel at or after rr_q.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = (32'(rr_q) + i) % N_CH;
         if (!gnt_found && bus.in_valid[CH_W'(idx)]) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(idx);
         end
      end
   end

   // Grant is only visible in IDLE and never while reset is asserted.
   always_comb begin
      ready_c = '0;
      if (reset_n && state_q == IDLE && gnt_found) ready_c[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_nx = state_q;
      rr_nx    = rr_q;
      sh_nx    = sh_q;
      rcv_nx   = rcv_q;
      acc_nx   = acc_q;
      cnt_nx   = cnt_q;
      rv_nx    = rv_q;
      rch_nx   = rch_q;
      rok_nx   = rok_q;
      rcrc_nx  = rcrc_q;
      ecnt_nx  = ecnt_q;
      eflg_nx  = eflg_q;
      busy_nx  = busy_q;

      unique case (state_q)
         IDLE: begin
            if (gnt_found) begin
               sh_nx    = bus.in_data[32'(gnt_idx)*DATA_W +: DATA_W];
               rcv_nx   = bus.in_crc[32'(gnt_idx)*CRC_W +: CRC_W];
               rch_nx   = gnt_idx;
               rr_nx    = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
               acc_nx   = '0;
               cnt_nx   = '0;
               state_nx = CALC;
            end
         end
         CALC: begin
            sh_nx  = sh_q << BITS_PER_CYC;
            acc_nx = step_crc;
            cnt_nx = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(CALC_CYC - 1)) begin
               rcrc_nx  = step_crc;
               rok_nx   = (step_crc == rcv_q);
               rv_nx    = 1'b1;
               state_nx = RESULT;
            end
         end
         RESULT: begin
            if (bus.res_ready) begin
               rv_nx    = 1'b0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      // Clear first, then a failing delivery in the same cycle still counts.
      if (clr_err) begin
         ecnt_nx = '0;
         eflg_nx = '0;
      end
      if (rv_q && bus.res_ready && !rok_q) begin
         if (ecnt_nx != '1) ecnt_nx = ecnt_nx + 1'b1;
         eflg_nx[rch_q] = 1'b1;
      end

      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         sh_q    <= '0;
         rcv_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         rv_q    <= 1'b0;
         rch_q   <= '0;
         rok_q   <= 1'b0;
         rcrc_q  <= '0;
         ecnt_q  <= '0;
         eflg_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         rr_q    <= rr_nx;
         sh_q    <= sh_nx;
         rcv_q   <= rcv_nx;
         acc_q   <= acc_nx;
         cnt_q   <= cnt_nx;
         rv_q    <= rv_nx;
         rch_q   <= rch_nx;
         rok_q   <= rok_nx;
         rcrc_q  <= rcrc_nx;
         ecnt_q  <= ecnt_nx;
         eflg_q  <= eflg_nx;
         busy_q  <= busy_nx;
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.res_valid = rv_q;
   assign bus.res_ch    = rch_q;
   assign bus.res_ok    = rok_q;
   assign bus.res_crc   = rcrc_q;
   assign err_cnt       = ecnt_q;
   assign err_flags     = eflg_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_crc_check_engine.sv
// Self-checking bench for crc_check_engine: directed vector table, multi-cycle corner
// sequences and randomized traffic against a polynomial long-division reference model.
module tb_crc_check_engine;
   localparam int unsigned N_CH     = 16;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned CRC_W    = 4;
   localparam int unsigned BPC      = 8;
   localparam int unsigned CALC_CYC = DATA_W / BPC;
   // Narrow counter so saturation is reachable in a short run.
   localparam int unsigned ERR_W    = 8;
   localparam logic [CRC_W:0] GEN   = 5'b10011;

   logic clock = 1'b0;
   logic reset_n;
   logic clr_err;
   logic [ERR_W-1:0] err_cnt;
   logic [N_CH-1:0]  err_flags;
   logic busy;

   crc_check_engine_if #(.N_CH(N_CH), .DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

   crc_check_engine #(
      .N_CH(N_CH), .DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(4'h3),
      .BITS_PER_CYC(BPC), .ERR_W(ERR_W)
   ) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus), .clr_err(clr_err),
      .err_cnt(err_cnt), .err_flags(err_flags), .busy(busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] ch_data [N_CH];
   logic [CRC_W-1:0]  ch_crc  [N_CH];
   int                exp_rr;
   logic [ERR_W-1:0]  exp_cnt;
   logic [N_CH-1:0]   exp_flags;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Remainder of d(x)*x^CRC_W mod G(x) by plain long division.
   function automatic logic [CRC_W-1:0] ref_crc(input logic [DATA_W-1:0] d);
      logic [DATA_W+CRC_W-1:0] r;
      r = {d, {CRC_W{1'b0}}};
      for (int i = DATA_W + CRC_W - 1; i >= int'(CRC_W); i--)
         if (r[i]) r[i -: CRC_W+1] = r[i -: CRC_W+1] ^ GEN;
      return r[CRC_W-1:0];
   endfunction

   function automatic int model_grant(input logic [N_CH-1:0] v, input int rr);
      for (int k = 0; k < int'(N_CH); k++)
         if (v[(rr + k) % N_CH]) return (rr + k) % N_CH;
      return -1;
   endfunction

   task automatic drive_data();
      for (int c = 0; c < int'(N_CH); c++) begin
         bus.in_data[c*DATA_W +: DATA_W] = ch_data[c];
         bus.in_crc[c*CRC_W +: CRC_W]    = ch_crc[c];
      end
   endtask

   // One full transaction starting in IDLE, #1 after a rising edge.
   task automatic xact(input logic [N_CH-1:0] vmask, input int hold, input bit clr,
                       input bit has_exp, input logic [CRC_W-1:0] t_crc, input bit t_ok);
      int g, cyc;
      bit seen, leak, unstable;
      logic [CRC_W-1:0] e_crc;
      bit e_ok;
      logic [N_CH-1:0] oh;
      g = model_grant(vmask, exp_rr);
      if (g < 0) g = 0;
      e_crc = has_exp ? t_crc : ref_crc(ch_data[g]);
      e_ok  = has_exp ? t_ok  : (ref_crc(ch_data[g]) == ch_crc[g]);
      oh = '0;
      oh[g] = 1'b1;
      drive_data();
      bus.in_valid  = vmask;
      bus.res_ready = 1'b0;
      clr_err       = 1'b0;
      #1;
      check("grant", 64'(bus.in_ready), 64'(oh));
      @(posedge clock); #1;
      check("busy_calc", 64'(busy), 64'd1);
      cyc = 0; seen = 0; leak = 0;
      while (cyc < int'(CALC_CYC) + 4 && !seen) begin
         if (bus.in_ready != '0) leak = 1;
         @(posedge clock); #1;
         cyc++;
         if (bus.res_valid) seen = 1;
      end
      check("latency", seen ? 64'(cyc) : 64'hFFFF, 64'(CALC_CYC));
      check("res_ch", 64'(bus.res_ch), 64'(g));
      check("res_crc", 64'(bus.res_crc), 64'(e_crc));
      check("res_ok", 64'(bus.res_ok), 64'(e_ok));
      unstable = 0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clock); #1;
         if (bus.in_ready != '0) leak = 1;
         if (!bus.res_valid || bus.res_ch != 4'(g) || bus.res_crc != e_crc || bus.res_ok != e_ok)
            unstable = 1;
      end
      check("ready_leak", 64'(leak), 64'd0);
      if (hold > 0) check("hold_stable", 64'(unstable), 64'd0);
      bus.res_ready = 1'b1;
      clr_err       = clr;
      if (clr) begin
         exp_cnt   = '0;
         exp_flags = '0;
      end
      if (!e_ok) begin
         if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
         exp_flags[g] = 1'b1;
      end
      @(posedge clock); #1;
      bus.res_ready = 1'b0;
      clr_err       = 1'b0;
      bus.in_valid  = '0;
      check("res_valid_drop", 64'(bus.res_valid), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
      check("err_flags", 64'(err_flags), 64'(exp_flags));
      exp_rr = (g + 1) % N_CH;
   endtask

   typedef struct {
      int                ch;
      logic [DATA_W-1:0] data;
      logic [CRC_W-1:0]  crc;
      int                hold;
      logic [CRC_W-1:0]  exp_crc;
      bit                exp_ok;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t exceeded budget", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{ch: 0,  data: 64'h1,  crc: 4'h3, hold: 0,  exp_crc: 4'h3, exp_ok: 1'b1};
      tbl[1] = '{ch: 0,  data: 64'h2,  crc: 4'h1, hold: 0,  exp_crc: 4'h6, exp_ok: 1'b0};
      tbl[2] = '{ch: 5,  data: 64'h8,  crc: 4'hB, hold: 20, exp_crc: 4'hB, exp_ok: 1'b1};
      tbl[3] = '{ch: 3,  data: 64'hF,  crc: 4'h0, hold: 2,  exp_crc: 4'h2, exp_ok: 1'b0};
      tbl[4] = '{ch: 9,  data: 64'h10, crc: 4'h5, hold: 0,  exp_crc: 4'h5, exp_ok: 1'b1};
      tbl[5] = '{ch: 15, data: 64'h0,  crc: 4'h0, hold: 0,  exp_crc: 4'h0, exp_ok: 1'b1};

      for (int c = 0; c < int'(N_CH); c++) begin
         ch_data[c] = '0;
         ch_crc[c]  = '0;
      end
      reset_n = 1'b0; clr_err = 1'b0;
      bus.in_valid = '0; bus.res_ready = 1'b0; bus.in_data = '0; bus.in_crc = '0;
      exp_rr = 0; exp_cnt = '0; exp_flags = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("rst_res_ch", 64'(bus.res_ch), 64'd0);
      check("rst_res_ok", 64'(bus.res_ok), 64'd0);
      check("rst_res_crc", 64'(bus.res_crc), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_err_flags", 64'(err_flags), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset_n = 1'b1;

      // Directed vector table, one requesting channel at a time.
      foreach (tbl[i]) begin
         ch_data[tbl[i].ch] = tbl[i].data;
         ch_crc[tbl[i].ch]  = tbl[i].crc;
         xact(N_CH'(1) << tbl[i].ch, tbl[i].hold, 1'b0, 1'b1, tbl[i].exp_crc, tbl[i].exp_ok);
      end

      // All channels requesting with zero data: strict rotation 0..15 then 0.
      for (int c = 0; c < int'(N_CH); c++) begin
         ch_data[c] = '0;
         ch_crc[c]  = '0;
      end
      for (int k = 0; k <= int'(N_CH); k++) xact('1, 0, 1'b0, 1'b0, '0, 1'b0);

      // Reset four cycles into CALC discards the word and the pointer.
      ch_data[0] = {$urandom, $urandom};
      ch_crc[0]  = ref_crc(ch_data[0]);
      ch_data[3] = 64'h3;
      ch_crc[3]  = 4'h0;
      drive_data();
      bus.in_valid = 16'h0001;
      @(posedge clock); #1;
      check("pre_rst_busy", 64'(busy), 64'd1);
      repeat (4) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_res_ch", 64'(bus.res_ch), 64'd0);
      check("mid_rst_res_crc", 64'(bus.res_crc), 64'd0);
      check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
      check("mid_rst_err_flags", 64'(err_flags), 64'd0);
      repeat (4) @(posedge clock);
      #1;
      check("held_rst_res_valid", 64'(bus.res_valid), 64'd0);
      reset_n = 1'b1;
      exp_rr = 0; exp_cnt = '0; exp_flags = '0;
      xact(16'h0009, 0, 1'b0, 1'b0, '0, 1'b0);
      xact(16'h0008, 0, 1'b0, 1'b0, '0, 1'b0);

      // Randomized traffic: random request masks, data and good/bad check values.
      for (int n = 0; n < 40; n++) begin
         logic [N_CH-1:0] m;
         for (int c = 0; c < int'(N_CH); c++) begin
            ch_data[c] = {$urandom, $urandom};
            ch_crc[c]  = ($urandom_range(0, 1) != 0) ? ref_crc(ch_data[c]) : CRC_W'($urandom);
         end
         m = N_CH'($urandom);
         if (m == '0) m = N_CH'(1) << $urandom_range(0, N_CH - 1);
         xact(m, int'($urandom_range(0, 3)), 1'b0, 1'b0, '0, 1'b0);
      end

      // Drive the counter to saturation and past it with guaranteed failures.
      for (int n = 0; n < (1 << ERR_W) + 2 && (exp_cnt != '1 || n < 3); n++) begin
         int c;
         c = int'($urandom_range(0, N_CH - 1));
         ch_data[c] = {$urandom, $urandom};
         ch_crc[c]  = ref_crc(ch_data[c]) ^ 4'h1;
         xact(N_CH'(1) << c, 0, 1'b0, 1'b0, '0, 1'b0);
      end
      check("err_cnt_saturated", 64'(err_cnt), 64'(ERR_W'('1)));

      // Clear coinciding with a failing delivery leaves exactly that one failure.
      ch_data[6] = 64'h2;
      ch_crc[6]  = 4'h1;
      xact(16'h0040, 1, 1'b1, 1'b0, '0, 1'b0);
      check("clr_fail_cnt", 64'(err_cnt), 64'd1);
      check("clr_fail_flags", 64'(err_flags), 64'h0040);

      // Standalone clear in IDLE.
      clr_err = 1'b1;
      @(posedge clock); #1;
      clr_err = 1'b0;
      check("clr_only_cnt", 64'(err_cnt), 64'd0);
      check("clr_only_flags", 64'(err_flags), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
